// File: rtl/ball_pkg.sv
// Shared definitions for the ball-position engine.
// Ports: none (package). Provides the FSM state encoding and direction constants
// used by ball_motion and its per-axis helper.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b1;  // x increasing
  localparam logic DIR_DOWN  = 1'b1;  // y increasing

endpackage

// File: rtl/ball_axis.sv
// Single-axis step/reflect calculator (purely combinational).
// Ports: pos/dir = current registered coordinate and direction, bounce = collision
//   request to invert dir, step_en = move this cycle; next_pos/next_dir = proposed
//   update, hit_max/hit_min = the move reached the far/near limit.
module ball_axis #(
  parameter int W     = 10,
  parameter int LIMIT = 636,
  parameter int STEP  = 1
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  input  logic         bounce,
  input  logic         step_en,
  output logic [W-1:0] next_pos,
  output logic         next_dir,
  output logic         hit_max,
  output logic         hit_min
);

  // Arithmetic is one bit wider than the coordinate so pos+STEP can never wrap.
  localparam logic [W:0] STEP_EXT  = (W+1)'(STEP);
  localparam logic [W:0] LIMIT_EXT = (W+1)'(LIMIT);

  logic       eff_dir;
  logic [W:0] pos_ext;

  assign eff_dir = dir ^ bounce;
  assign pos_ext = {1'b0, pos};

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    hit_max  = 1'b0;
    hit_min  = 1'b0;
    if (step_en) begin
      if (eff_dir) begin
        if (pos_ext + STEP_EXT >= LIMIT_EXT) begin
          // Clamp onto the limit and reflect.
          next_pos = W'(LIMIT);
          next_dir = 1'b0;
          hit_max  = 1'b1;
        end else begin
          next_pos = W'(pos_ext + STEP_EXT);
          next_dir = 1'b1;
        end
      end else begin
        if (pos_ext <= STEP_EXT) begin
          // Clamp onto zero instead of underflowing, then reflect.
          next_pos = '0;
          next_dir = 1'b1;
          hit_min  = 1'b1;
        end else begin
          next_pos = W'(pos_ext - STEP_EXT);
          next_dir = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball-position engine: steps (x,y) per enable tick, reflects off left/right/top
//   walls, applies collision bounces and pulses lost when the ball exits the bottom.
// Ports: clk, reset (async, active-high), enable (motion tick), launch (start from
//   IDLE), bounce_x/bounce_y (collision inversions); x, y, x_dir, y_dir registered,
//   moving = in MOVE, lost = one-cycle pulse in LOST.
module ball_motion
  import ball_pkg::*;
#(
  parameter int W         = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1,
  parameter int X_INIT    = 318,
  parameter int Y_INIT    = 400
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         launch,
  input  logic         bounce_x,
  input  logic         bounce_y,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         x_dir,
  output logic         y_dir,
  output logic         moving,
  output logic         lost
);

  localparam int XR = X_MAX - BALL_SIZE + 1;
  localparam int YB = Y_MAX - BALL_SIZE + 1;

  state_t       state, state_nx;
  logic [W-1:0] x_nx, y_nx;
  logic         x_dir_nx, y_dir_nx;

  logic [W-1:0] x_step_pos, y_step_pos;
  logic         x_step_dir, y_step_dir;
  logic         y_hit_max;
  logic         step_en;

  assign step_en = (state == MOVE) && enable;

  ball_axis #(.W(W), .LIMIT(XR), .STEP(STEP)) u_axis_x (
    .pos      (x),
    .dir      (x_dir),
    .bounce   (bounce_x),
    .step_en  (step_en),
    .next_pos (x_step_pos),
    .next_dir (x_step_dir),
    .hit_max  (),
    .hit_min  ()
  );

  // The bottom is not a wall: reaching YB exactly is still in play and only
  // stepping strictly past it loses the ball. Using YB+1 as the axis limit turns
  // the axis's ">=" test into "> YB"; the clamped position it proposes is unused
  // because the FSM pins y to YB itself on the losing tick.
  ball_axis #(.W(W), .LIMIT(YB + 1), .STEP(STEP)) u_axis_y (
    .pos      (y),
    .dir      (y_dir),
    .bounce   (bounce_y),
    .step_en  (step_en),
    .next_pos (y_step_pos),
    .next_dir (y_step_dir),
    .hit_max  (y_hit_max),
    .hit_min  ()
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= W'(X_INIT);
      y     <= W'(Y_INIT);
      x_dir <= DIR_RIGHT;
      y_dir <= ~DIR_DOWN;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      x_dir <= x_dir_nx;
      y_dir <= y_dir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    x_dir_nx = x_dir;
    y_dir_nx = y_dir;
    case (state)
      IDLE: begin
        x_nx     = W'(X_INIT);
        y_nx     = W'(Y_INIT);
        x_dir_nx = DIR_RIGHT;
        y_dir_nx = ~DIR_DOWN;
        if (launch) state_nx = MOVE;
      end
      MOVE: begin
        if (enable) begin
          x_nx     = x_step_pos;
          x_dir_nx = x_step_dir;
          if (y_hit_max) begin
            y_nx     = W'(YB);
            y_dir_nx = DIR_DOWN;
            state_nx = LOST;
          end else begin
            y_nx     = y_step_pos;
            y_dir_nx = y_step_dir;
          end
        end
      end
      LOST: begin
        // Reload on the way out so the first IDLE cycle already shows INIT.
        state_nx = IDLE;
        x_nx     = W'(X_INIT);
        y_nx     = W'(Y_INIT);
        x_dir_nx = DIR_RIGHT;
        y_dir_nx = ~DIR_DOWN;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign moving = (state == MOVE);
  assign lost   = (state == LOST);

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       launch = 1'b0;
  logic       bounce_x = 1'b0;
  logic       bounce_y = 1'b0;
  logic [9:0] x, y;
  logic       x_dir, y_dir, moving, lost;

  ball_motion dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .launch   (launch),
    .bounce_x (bounce_x),
    .bounce_y (bounce_y),
    .x        (x),
    .y        (y),
    .x_dir    (x_dir),
    .y_dir    (y_dir),
    .moving   (moving),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       xd;
    logic       yd;
    logic       mv;
    logic       lo;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: ball as plain integers plus "in play" / "just lost" flags.
  localparam int XR = 636;
  localparam int YB = 476;
  int mx = 318, my = 400;
  bit mxd = 1'b1, myd = 1'b0, mact = 1'b0, mlost = 1'b0;

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 10'(mx); o.y = 10'(my); o.xd = mxd; o.yd = myd; o.mv = mact; o.lo = mlost;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = x; o.y = y; o.xd = x_dir; o.yd = y_dir; o.mv = moving; o.lo = lost;
    return o;
  endfunction

  task automatic model_home();
    mx = 318; my = 400; mxd = 1'b1; myd = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit en, input bit la, input bit bx, input bit by);
    bit ex, ey;
    if (r) begin
      model_home(); mact = 0; mlost = 0;
    end else if (mlost) begin
      mlost = 0; model_home();
    end else if (!mact) begin
      model_home();
      if (la) mact = 1;
    end else if (en) begin
      ex = mxd ^ bx;
      ey = myd ^ by;
      if (ex) begin
        if (mx + 1 >= XR) begin mx = XR; mxd = 0; end
        else begin mx = mx + 1; mxd = 1; end
      end else begin
        if (mx <= 1) begin mx = 0; mxd = 1; end
        else begin mx = mx - 1; mxd = 0; end
      end
      if (ey) begin
        if (my + 1 > YB) begin my = YB; myd = 1; mact = 0; mlost = 1; end
        else begin my = my + 1; myd = 1; end
      end else begin
        if (my <= 1) begin my = 0; myd = 1; end
        else begin my = my - 1; myd = 0; end
      end
    end
  endtask

  // Drive one clock cycle of stimulus and queue the expected post-edge outputs.
  task automatic tick(input bit r, input bit en, input bit la, input bit bx, input bit by);
    @(negedge clk);
    reset = r; enable = en; launch = la; bounce_x = bx; bounce_y = by;
    model_step(r, en, la, bx, by);
    exp_q.push_back(model_obs());
    @(posedge clk);
  endtask

  task automatic check_const(input string name, input obs_t req);
    obs_t act;
    act = dut_obs();
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d xd=%0b yd=%0b mv=%0b lost=%0b, want x=%0d y=%0d xd=%0b yd=%0b mv=%0b lost=%0b",
               name, act.x, act.y, act.xd, act.yd, act.mv, act.lo,
               req.x, req.y, req.xd, req.yd, req.mv, req.lo);
    end
  endtask

  // Monitor: every clock, compare the DUT against the oldest queued expectation.
  always @(posedge clk) begin
    obs_t e, a;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got x=%0d y=%0d xd=%0b yd=%0b mv=%0b lost=%0b, want x=%0d y=%0d xd=%0b yd=%0b mv=%0b lost=%0b",
                 $time, a.x, a.y, a.xd, a.yd, a.mv, a.lo, e.x, e.y, e.xd, e.yd, e.mv, e.lo);
      end
    end
  end

  initial begin
    int n;
    // Reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 1);
    #3 check_const("reset_state", {10'd318, 10'd400, 1'b1, 1'b0, 1'b0, 1'b0});

    // Launch and three enables
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
    #3 check_const("launch_3_steps", {10'd321, 10'd397, 1'b1, 1'b0, 1'b1, 1'b0});

    // Asynchronous reset in the middle of a cycle while moving
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_const("async_reset", {10'd318, 10'd400, 1'b1, 1'b0, 1'b0, 1'b0});
    model_step(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);

    // Run into the right wall, then back toward x=100
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 317; i++) tick(0, 1, 0, 0, 0);
    #3 check_const("before_right_wall", {10'd635, 10'd83, 1'b1, 1'b0, 1'b1, 1'b0});
    tick(0, 1, 0, 0, 0);
    #3 check_const("right_wall", {10'd636, 10'd82, 1'b0, 1'b0, 1'b1, 1'b0});
    n = 0;
    while (mx != 100 && n < 700) begin tick(0, 1, 0, 0, 0); n++; end
    checks++;
    if (mx != 100) begin failures++; $display("FAIL reach_x100: got x=%0d want 100", mx); end
    tick(0, 1, 0, 1, 0);
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 0);

    // Corner: line x and y up, then reach (0,0) on the same tick
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 83; i++) tick(0, 1, 0, 1, 0);
    for (int i = 0; i < 317; i++) tick(0, 1, 0, 0, 0);
    #3 check_const("corner", {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    tick(0, 1, 0, 0, 0);
    #3 check_const("after_corner", {10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0});

    // Bottom edge: run down until the model says lost (bounded)
    n = 0;
    while (!mlost && n < 600) begin tick(0, 1, 0, 0, 0); n++; end
    #3 check_const("lost_pulse", {10'd477, 10'd476, 1'b1, 1'b1, 1'b0, 1'b1});
    tick(0, 1, 1, 0, 0);
    #3 check_const("after_lost", {10'd318, 10'd400, 1'b1, 1'b0, 1'b0, 1'b0});

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom % 500) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
           ($urandom % 16) == 0, ($urandom % 12) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
